// File: rtl/sub16_nibble_serial.sv
// rtl/sub16_nibble_serial.sv - nibble-serial W-bit subtractor (A - B - bin), one 4-bit slice per cycle
module sub16_nibble_serial #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);
    localparam int NIB = W / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_sh, b_sh, res, res_nx;
    logic           a_msb, b_msb, carry;
    logic [CW-1:0]  cnt;
    logic           last, accept;
    logic [3:0]     an, bn, g, p, sum;
    logic           c1, c2, c3, c4;

    // Operands shift right one nibble per cycle, so the active slice is always [3:0]
    assign an  = a_sh[3:0];
    assign bn  = ~b_sh[3:0];
    assign g   = an & bn;
    assign p   = an ^ bn;
    assign c1  = g[0] | (p[0] & carry);
    assign c2  = g[1] | (p[1] & c1);
    assign c3  = g[2] | (p[2] & c2);
    assign c4  = g[3] | (p[3] & c3);
    assign sum = p ^ {c3, c2, c1, carry};

    // Result fills from the top so the LSB nibble lands at [3:0] after NIB shifts
    assign res_nx = (res >> 4) | (W'(sum) << (W - 4));
    assign last   = (cnt == CW'(NIB - 1));
    assign accept = start && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            res   <= '0;
            a_msb <= A[W-1];
            b_msb <= B[W-1];
            carry <= ~bin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            res   <= res_nx;
            carry <= c4;
            cnt   <= cnt + 1'b1;
            if (last) begin
                diff <= res_nx;
                bout <= ~c4;
                ovf  <= (a_msb != b_msb) && (res_nx[W-1] != a_msb);
                zero <= (res_nx == '0);
            end
        end
    end
endmodule

// File: tb/tb_sub16_nibble_serial.sv
// tb/tb_sub16_nibble_serial.sv - directed vector bench for sub16_nibble_serial
module tb_sub16_nibble_serial;
    logic        clk = 1'b0;
    logic        rst, start, bin;
    logic [15:0] A, B;
    logic        busy, done, bout, ovf, zero;
    logic [15:0] diff;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    sub16_nibble_serial #(.W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Steps from cycle 1 until done; returns cycle index of done and busy-cycle count
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (done !== 1'b1 && lat < 14) begin
            if (busy === 1'b1) bc++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, bc;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b1; A = 16'hFFFF; B = 16'h1234; bin = 1'b1;
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_flags", {bout, ovf, zero}, 0);
        start = 1'b0;
        rst   = 1'b0;
        step();

        foreach (vecs[i]) begin
            A = vecs[i].a; B = vecs[i].b; bin = vecs[i].bi; start = 1'b1;
            step();
            start = 1'b0; A = ~vecs[i].a; B = ~vecs[i].b; bin = ~vecs[i].bi;
            wait_done(lat, bc);
            chk($sformatf("v%0d_latency", i), lat, 5);
            chk($sformatf("v%0d_busy_cycles", i), bc, 4);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            chk($sformatf("v%0d_diff", i), diff, vecs[i].d);
            chk($sformatf("v%0d_bout", i), bout, vecs[i].bo);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            step();
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Abort mid-run, then a run with start held high throughout
        A = 16'hFFFF; B = 16'h0001; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_outputs", {diff, bout, ovf, zero}, 0);
        A = 16'h0003; B = 16'h0001; start = 1'b1;
        step();
        chk("abort_no_done", done, 0);
        A = 16'hFFFF; B = 16'hFFFF; bin = 1'b1;
        wait_done(lat, bc);
        chk("held_latency", lat, 5);
        chk("held_diff", diff, 16'h0002);
        chk("held_bout", bout, 0);
        start = 1'b0;
        step();
        step();

        // Back-to-back: second op accepted in the DONE cycle
        A = 16'h0010; B = 16'h0001; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, bc);
        chk("b2b_first_latency", lat, 5);
        chk("b2b_first_diff", diff, 16'h000F);
        A = 16'h0001; B = 16'h0002; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 6; c <= 9; c++) begin
            chk($sformatf("b2b_hold_diff_c%0d", c), diff, 16'h000F);
            chk($sformatf("b2b_busy_c%0d", c), busy, 1);
            if (c < 9) step();
        end
        step();
        chk("b2b_second_done", done, 1);
        chk("b2b_second_diff", diff, 16'hFFFF);
        chk("b2b_second_bout", bout, 1);
        step();
        chk("b2b_idle", {busy, done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
